dzcpu_ucode_seq: RTL and testbench

Parametrised, RAM-backed microcode sequencer for the dzcpu core.
- Holds a writable micro-op store and two writable 256-entry dispatch tables: the main table and the 0xCB-prefix table.
- Turns accepted opcodes into a registered, stall-aware micro-op stream.
- Supports zero-bubble back-to-back flows, CB-prefix dispatch and interrupt flow entry at instruction boundaries.
- Sits between the opcode fetch path and the dzcpu datapath decoder. It replaces fixed case-table dispatch.

---
 rtl/dzcpu_ucode_seq_if.sv | 34 +++
 rtl/dzcpu_ucode_seq.sv | 132 +++++++++++++
 tb/tb_dzcpu_ucode_seq.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_ucode_seq_if.sv
// Opcode, micro-op and table-write signals between the dzcpu fetch/datapath
// side (master) and the microcode sequencer (slave).
interface dzcpu_ucode_seq_if #(
    parameter int ADDR_W = 8,
    parameter int UOP_W  = 13
);
    logic [7:0]        iMop;
    logic              iMopValid;
    logic              oReady;
    logic              iStall;
    logic              iIrq;
    logic              iIrqEn;
    logic              oIrqAck;
    logic [UOP_W-1:0]  oUop;
    logic              oUopValid;
    logic [ADDR_W-1:0] oUpc;
    logic              oCbWait;
    logic              iWrEn;
    logic [1:0]        iWrSel;
    logic [ADDR_W-1:0] iWrAddr;
    logic [UOP_W-1:0]  iWrData;

    modport master (
        output iMop, iMopValid, iStall, iIrq, iIrqEn,
               iWrEn, iWrSel, iWrAddr, iWrData,
        input  oReady, oIrqAck, oUop, oUopValid, oUpc, oCbWait
    );

    modport slave (
        input  iMop, iMopValid, iStall, iIrq, iIrqEn,
               iWrEn, iWrSel, iWrAddr, iWrData,
        output oReady, oIrqAck, oUop, oUopValid, oUpc, oCbWait
    );
endinterface

// File: rtl/dzcpu_ucode_seq.sv
// RAM-backed microcode sequencer for dzcpu: dispatches opcodes (main and
// 0xCB-prefix tables) and interrupts into a registered, stall-aware micro-op stream.
module dzcpu_ucode_seq #(
    parameter int                ADDR_W   = 8,
    parameter int                UOP_W    = 13,
    parameter logic [ADDR_W-1:0] INT_FLOW = ADDR_W'(200)
) (
    input logic              iClock,
    input logic              iReset,
    dzcpu_ucode_seq_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    if (ADDR_W < 8) begin : g_addr_w_check
        $error("dzcpu_ucode_seq: ADDR_W must be >= 8");
    end
    if (UOP_W < ADDR_W + 2) begin : g_uop_w_check
        $error("dzcpu_ucode_seq: UOP_W must be >= ADDR_W+2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CBWAIT
    } state_t;

    state_t            state, state_nx;
    logic [UOP_W-1:0]  store    [DEPTH];
    logic [ADDR_W-1:0] main_tbl [256];
    logic [ADDR_W-1:0] cb_tbl   [256];

    logic [UOP_W-1:0]  uop_q;
    logic [ADDR_W-1:0] upc_q, upc_nx;
    logic              valid_q, valid_nx;
    logic              ack_q, ack_nx;
    logic              load_uop;

    logic              eof, jcb;
    logic              boundary, irq_take, ready, accept;

    // Control bits live at the top of every micro-op; EOF outranks JCB.
    assign eof = uop_q[UOP_W-1];
    assign jcb = uop_q[UOP_W-2];

    assign boundary = (state == S_IDLE) ||
                      ((state == S_RUN) && valid_q && eof && !bus.iStall);
    assign irq_take = boundary && bus.iIrq && bus.iIrqEn;
    assign ready    = (boundary && !irq_take) || (state == S_CBWAIT);
    assign accept   = bus.iMopValid && ready;

    // NOTE: tables are plain RAM with no reset, so their contents survive
    // iReset; only the sequencing state below is cleared.
    always_ff @(posedge iClock) begin
        if (bus.iWrEn) begin
            case (bus.iWrSel)
                2'd0:    store[bus.iWrAddr]         <= bus.iWrData;
                2'd1:    main_tbl[bus.iWrAddr[7:0]] <= bus.iWrData[ADDR_W-1:0];
                2'd2:    cb_tbl[bus.iWrAddr[7:0]]   <= bus.iWrData[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: every signal gets a default before any branch so that no path
    // through this block leaves a value unassigned (which would infer a latch).
    always_comb begin
        state_nx = state;
        upc_nx   = upc_q;
        valid_nx = valid_q;
        ack_nx   = 1'b0;
        load_uop = 1'b0;

        if (irq_take) begin
            upc_nx   = INT_FLOW;
            load_uop = 1'b1;
            valid_nx = 1'b1;
            ack_nx   = 1'b1;
            state_nx = S_RUN;
        end else if (accept) begin
            upc_nx   = (state == S_CBWAIT) ? cb_tbl[bus.iMop] : main_tbl[bus.iMop];
            load_uop = 1'b1;
            valid_nx = 1'b1;
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (!bus.iStall) begin
                        if (eof) begin
                            state_nx = S_IDLE;
                            valid_nx = 1'b0;
                        end else if (jcb) begin
                            state_nx = S_CBWAIT;
                            valid_nx = 1'b0;
                        end else begin
                            upc_nx   = upc_q + ADDR_W'(1);
                            load_uop = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state   <= S_IDLE;
            upc_q   <= '0;
            uop_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            upc_q   <= upc_nx;
            valid_q <= valid_nx;
            ack_q   <= ack_nx;
            // Store is read before the same-edge write lands, giving old data.
            if (load_uop) begin
                uop_q <= store[upc_nx];
            end
        end
    end

    assign bus.oReady    = ready;
    assign bus.oIrqAck   = ack_q;
    assign bus.oUop      = uop_q;
    assign bus.oUopValid = valid_q;
    assign bus.oUpc      = upc_q;
    assign bus.oCbWait   = (state == S_CBWAIT);
endmodule

// File: tb/tb_dzcpu_ucode_seq.sv
// Self-checking bench for dzcpu_ucode_seq: a scoreboard of expected micro-ops
// consumed by the datapath, plus per-scenario checks of handshake outputs.
module tb_dzcpu_ucode_seq;
    localparam int ADDR_W = 8;
    localparam int UOP_W  = 13;

    typedef struct {
        logic [ADDR_W-1:0] upc;
        logic [UOP_W-1:0]  uop;
    } exp_t;

    logic iClock = 1'b0;
    logic iReset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    dzcpu_ucode_seq_if #(.ADDR_W(ADDR_W), .UOP_W(UOP_W)) bus ();

    dzcpu_ucode_seq #(
        .ADDR_W  (ADDR_W),
        .UOP_W   (UOP_W),
        .INT_FLOW(8'd200)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus   (bus)
    );

    always #5 iClock = ~iClock;

    // A micro-op is consumed when valid and not stalled at the coming edge.
    always @(negedge iClock) begin : scoreboard
        exp_t e;
        if (iReset && bus.oUopValid && !bus.iStall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL uop_stream: got unexpected upc=%0d uop=%h, expected none", bus.oUpc, bus.oUop);
            end else begin
                e = exp_q.pop_front();
                if (bus.oUpc !== e.upc || bus.oUop !== e.uop) begin
                    errors++;
                    $display("FAIL uop_stream: got upc=%0d uop=%h, expected upc=%0d uop=%h",
                             bus.oUpc, bus.oUop, e.upc, e.uop);
                end
            end
        end
    end

    task automatic cyc;
        @(posedge iClock);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [UOP_W-1:0] u);
        exp_q.push_back('{upc: a, uop: u});
    endtask

    task automatic wr(input logic [1:0] sel, input logic [ADDR_W-1:0] a, input logic [UOP_W-1:0] d);
        bus.iWrEn   = 1'b1;
        bus.iWrSel  = sel;
        bus.iWrAddr = a;
        bus.iWrData = d;
        cyc();
        bus.iWrEn   = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({bus.oUopValid, bus.oIrqAck, bus.oCbWait} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got valid/ack/cbwait=%b, expected 000",
                     {bus.oUopValid, bus.oIrqAck, bus.oCbWait});
        end
        checks++;
        if (bus.oUpc !== 8'd0 || bus.oUop !== 13'd0) begin
            errors++;
            $display("FAIL reset_regs: got upc=%0d uop=%h, expected 0 and 0", bus.oUpc, bus.oUop);
        end
        @(posedge iClock);
        #1;
        iReset = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 1", bus.oReady);
        end
    endtask

    task automatic load_tables;
        wr(2'd0, 8'd5,   13'h0005);
        wr(2'd0, 8'd6,   13'h0006);
        wr(2'd0, 8'd7,   13'h1007);
        wr(2'd1, 8'h21,  13'd5);
        wr(2'd0, 8'd0,   13'h1000);
        wr(2'd1, 8'h00,  13'd0);
        wr(2'd0, 8'd13,  13'h0800);
        wr(2'd1, 8'hCB,  13'd13);
        wr(2'd2, 8'h7C,  13'd16);
        wr(2'd0, 8'd16,  13'h1010);
        wr(2'd0, 8'd200, 13'h10C8);
        wr(2'd0, 8'd255, 13'h00FF);
        wr(2'd1, 8'h40,  13'd255);
        // Writes with select 3 must leave every table untouched.
        wr(2'd3, 8'd5,   13'h1FFF);
        wr(2'd3, 8'h21,  13'h0000);
    endtask

    task automatic test_flow;
        int n;
        push(8'd5, 13'h0005);
        push(8'd6, 13'h0006);
        push(8'd7, 13'h1007);
        bus.iMop = 8'h21;
        bus.iMopValid = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL flow_ready_idle: got %b, expected 1", bus.oReady);
        end
        cyc();
        bus.iMopValid = 1'b0;
        checks++;
        if (bus.oUpc !== 8'd5 || bus.oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL flow_latency: got upc=%0d valid=%b, expected 5 and 1", bus.oUpc, bus.oUopValid);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.oUopValid) n++;
            cyc();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL flow_valid_cycles: got %0d, expected 3", n);
        end
        checks++;
        if (bus.oReady !== 1'b1 || bus.oCbWait !== 1'b0) begin
            errors++;
            $display("FAIL flow_idle_after: got ready=%b cbwait=%b, expected 1 and 0", bus.oReady, bus.oCbWait);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flow_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        push(8'd5, 13'h0005);
        push(8'd6, 13'h0006);
        push(8'd7, 13'h1007);
        push(8'd0, 13'h1000);
        bus.iMop = 8'h21;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (bus.oUpc !== 8'd7 || bus.oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_eof: got upc=%0d valid=%b, expected 7 and 1", bus.oUpc, bus.oUopValid);
        end
        bus.iMop = 8'h00;
        bus.iMopValid = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_at_eof: got %b, expected 1", bus.oReady);
        end
        cyc();
        bus.iMopValid = 1'b0;
        checks++;
        if (bus.oUpc !== 8'd0 || bus.oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bubble: got upc=%0d valid=%b, expected 0 and 1", bus.oUpc, bus.oUopValid);
        end
        cyc();
        checks++;
        if (bus.oUopValid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b pending=%0d, expected 0 and 0", bus.oUopValid, exp_q.size());
        end
    endtask

    task automatic test_cb;
        push(8'd13, 13'h0800);
        push(8'd16, 13'h1010);
        bus.iMop = 8'hCB;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        checks++;
        if (bus.oCbWait !== 1'b0 || bus.oUpc !== 8'd13) begin
            errors++;
            $display("FAIL cb_prefix_uop: got cbwait=%b upc=%0d, expected 0 and 13", bus.oCbWait, bus.oUpc);
        end
        cyc();
        checks++;
        if (bus.oCbWait !== 1'b1 || bus.oUopValid !== 1'b0) begin
            errors++;
            $display("FAIL cb_wait_enter: got cbwait=%b valid=%b, expected 1 and 0", bus.oCbWait, bus.oUopValid);
        end
        bus.iStall = 1'b1;
        cyc();
        checks++;
        if (bus.oCbWait !== 1'b1 || bus.oUopValid !== 1'b0) begin
            errors++;
            $display("FAIL cb_wait_hold: got cbwait=%b valid=%b, expected 1 and 0", bus.oCbWait, bus.oUopValid);
        end
        bus.iMop = 8'h7C;
        bus.iMopValid = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL cb_ready_stalled: got %b, expected 1", bus.oReady);
        end
        cyc();
        bus.iMopValid = 1'b0;
        bus.iStall = 1'b0;
        checks++;
        if (bus.oUpc !== 8'd16 || bus.oUop !== 13'h1010 || bus.oCbWait !== 1'b0) begin
            errors++;
            $display("FAIL cb_dispatch: got upc=%0d uop=%h cbwait=%b, expected 16 1010 0",
                     bus.oUpc, bus.oUop, bus.oCbWait);
        end
        cyc();
        checks++;
        if (bus.oUopValid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cb_end: got valid=%b pending=%0d, expected 0 and 0", bus.oUopValid, exp_q.size());
        end
    endtask

    task automatic test_stall;
        push(8'd5, 13'h0005);
        push(8'd6, 13'h0006);
        push(8'd7, 13'h1007);
        bus.iMop = 8'h21;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        cyc();
        bus.iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (bus.oUpc !== 8'd6 || bus.oUop !== 13'h0006 || bus.oUopValid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got upc=%0d uop=%h valid=%b, expected 6 0006 1",
                         bus.oUpc, bus.oUop, bus.oUopValid);
            end
        end
        bus.iStall = 1'b0;
        cyc();
        checks++;
        if (bus.oUpc !== 8'd7) begin
            errors++;
            $display("FAIL stall_release: got upc=%0d, expected 7", bus.oUpc);
        end
        cyc();
        checks++;
        if (bus.oUopValid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end: got valid=%b pending=%0d, expected 0 and 0", bus.oUopValid, exp_q.size());
        end
    endtask

    task automatic test_irq;
        int acks;
        push(8'd5,   13'h0005);
        push(8'd6,   13'h0006);
        push(8'd7,   13'h1007);
        push(8'd200, 13'h10C8);
        bus.iMop = 8'h21;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iIrq = 1'b1;
        bus.iIrqEn = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.oIrqAck !== 1'b0 || bus.oReady !== 1'b0) begin
                errors++;
                $display("FAIL irq_midflow: got ack=%b ready=%b at upc=%0d, expected 0 and 0",
                         bus.oIrqAck, bus.oReady, bus.oUpc);
            end
            cyc();
        end
        bus.iIrq = 1'b0;
        bus.iMopValid = 1'b0;
        checks++;
        if (bus.oIrqAck !== 1'b1 || bus.oUpc !== 8'd200 || bus.oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL irq_entry: got ack=%b upc=%0d valid=%b, expected 1 200 1",
                     bus.oIrqAck, bus.oUpc, bus.oUopValid);
        end
        cyc();
        checks++;
        if (bus.oIrqAck !== 1'b0 || bus.oUopValid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL irq_pulse_end: got ack=%b valid=%b pending=%0d, expected 0 0 0",
                     bus.oIrqAck, bus.oUopValid, exp_q.size());
        end

        bus.iIrq = 1'b1;
        bus.iIrqEn = 1'b0;
        push(8'd5, 13'h0005);
        push(8'd6, 13'h0006);
        push(8'd7, 13'h1007);
        bus.iMopValid = 1'b1;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL irq_masked_ready: got %b, expected 1", bus.oReady);
        end
        cyc();
        bus.iMopValid = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.oIrqAck) acks++;
            cyc();
        end
        bus.iIrq = 1'b0;
        checks++;
        if (acks !== 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL irq_masked: got acks=%0d pending=%0d, expected 0 and 0", acks, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        push(8'd255, 13'h00FF);
        push(8'd0,   13'h1000);
        bus.iMop = 8'h40;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        checks++;
        if (bus.oUpc !== 8'd255) begin
            errors++;
            $display("FAIL wrap_start: got upc=%0d, expected 255", bus.oUpc);
        end
        cyc();
        checks++;
        if (bus.oUpc !== 8'd0 || bus.oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_zero: got upc=%0d valid=%b, expected 0 and 1", bus.oUpc, bus.oUopValid);
        end
        cyc();
        checks++;
        if (bus.oUopValid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: got valid=%b pending=%0d, expected 0 and 0", bus.oUopValid, exp_q.size());
        end
    endtask

    task automatic test_reset_midflow;
        int n;
        push(8'd5, 13'h0005);
        bus.iMop = 8'h21;
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        cyc();
        iReset = 1'b0;
        #1;
        checks++;
        if (bus.oUpc !== 8'd0 || bus.oUop !== 13'd0 ||
            {bus.oUopValid, bus.oIrqAck, bus.oCbWait} !== 3'b000 || bus.oReady !== 1'b1) begin
            errors++;
            $display("FAIL midflow_reset: got upc=%0d uop=%h v/a/c=%b ready=%b, expected 0 0 000 1",
                     bus.oUpc, bus.oUop, {bus.oUopValid, bus.oIrqAck, bus.oCbWait}, bus.oReady);
        end
        cyc();
        iReset = 1'b1;
        #1;
        push(8'd5, 13'h0005);
        push(8'd6, 13'h0006);
        push(8'd7, 13'h1007);
        bus.iMopValid = 1'b1;
        cyc();
        bus.iMopValid = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.oUopValid) n++;
            cyc();
        end
        checks++;
        if (n !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL redispatch_after_reset: got valid_cycles=%0d pending=%0d, expected 3 and 0",
                     n, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iMop      = 8'h00;
        bus.iMopValid = 1'b0;
        bus.iStall    = 1'b0;
        bus.iIrq      = 1'b0;
        bus.iIrqEn    = 1'b0;
        bus.iWrEn     = 1'b0;
        bus.iWrSel    = 2'd0;
        bus.iWrAddr   = '0;
        bus.iWrData   = '0;

        test_reset();
        load_tables();
        test_flow();
        test_back_to_back();
        test_cb();
        test_stall();
        test_irq();
        test_wrap();
        test_reset_midflow();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
